// File: rtl/key_ctrl_pkg.sv
// Shared definitions for the key auto-repeat controller: code width, FSM states
// and default tick constants (10 MHz clock).
package key_ctrl_pkg;

    localparam int CODE_W = 5;
    localparam int TICK_W = 24;

    localparam logic [TICK_W-1:0] DEF_HOLD_TICKS   = 24'd5_000_000;
    localparam logic [TICK_W-1:0] DEF_REPEAT_TICKS = 24'd1_000_000;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_REPEAT  = 2'd2
    } key_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Small power-of-two command FIFO; head entry and occupancy come straight from
// registers so nothing on the consumer side sees a combinational input path.
module cmd_fifo #(
    parameter int DEPTH  = 4,
    parameter int CODE_W = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [CODE_W-1:0]       din,
    output logic [CODE_W-1:0]       dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [CODE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/key_repeat_ctrl.sv
// Keypad auto-repeat: one command on press, another after HOLD_TICKS, then one
// every REPEAT_TICKS while the same key stays down; commands queue in cmd_fifo.
module key_repeat_ctrl
    import key_ctrl_pkg::*;
#(
    parameter logic [TICK_W-1:0] HOLD_TICKS   = DEF_HOLD_TICKS,
    parameter logic [TICK_W-1:0] REPEAT_TICKS = DEF_REPEAT_TICKS,
    parameter int                DEPTH        = 4
) (
    input  logic                    hwclk,
    input  logic                    reset,
    input  logic [CODE_W-1:0]       key_code,
    input  logic                    key_held,
    input  logic                    cmd_ready,
    output logic                    cmd_valid,
    output logic [CODE_W-1:0]       cmd_code,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overflow
);

    key_state_t         state;
    logic [TICK_W-1:0]  cnt;
    logic [TICK_W-1:0]  limit;
    logic [CODE_W-1:0]  last_code;
    logic [CODE_W-1:0]  push_code;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;

    assign limit = (state == S_PRESSED) ? HOLD_TICKS - TICK_W'(1)
                                        : REPEAT_TICKS - TICK_W'(1);
    assign pop   = cmd_ready & ~empty;

    // Release beats everything; a changed code beats counter expiry.
    always_comb begin
        push      = 1'b0;
        push_code = key_code;
        if (state == S_IDLE) begin
            push = key_held;
        end else if (key_held) begin
            if (key_code != last_code) begin
                push = 1'b1;
            end else if (cnt == limit) begin
                push      = 1'b1;
                push_code = last_code;
            end
        end
    end

    always_ff @(posedge hwclk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            last_code <= '0;
            overflow  <= 1'b0;
        end else begin
            overflow <= overflow | (push & full & ~pop);
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (key_held) begin
                        last_code <= key_code;
                        state     <= S_PRESSED;
                    end
                end
                S_PRESSED, S_REPEAT: begin
                    if (!key_held) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else if (key_code != last_code) begin
                        last_code <= key_code;
                        cnt       <= '0;
                        state     <= S_PRESSED;
                    end else if (cnt == limit) begin
                        cnt   <= '0;
                        state <= S_REPEAT;
                    end else begin
                        cnt <= cnt + TICK_W'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    cmd_fifo #(
        .DEPTH  (DEPTH),
        .CODE_W (CODE_W)
    ) u_fifo (
        .clk   (hwclk),
        .rst   (reset),
        .push  (push),
        .pop   (pop),
        .din   (push_code),
        .dout  (cmd_code),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign cmd_valid = ~empty;

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// Directed bench for key_repeat_ctrl with HOLD_TICKS=8, REPEAT_TICKS=3, DEPTH=4.
module tb_key_repeat_ctrl;

    logic       hwclk;
    logic       reset;
    logic [4:0] key_code;
    logic       key_held;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [4:0] cmd_code;
    logic [2:0] fifo_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    key_repeat_ctrl #(
        .HOLD_TICKS   (24'd8),
        .REPEAT_TICKS (24'd3),
        .DEPTH        (4)
    ) dut (
        .hwclk      (hwclk),
        .reset      (reset),
        .key_code   (key_code),
        .key_held   (key_held),
        .cmd_ready  (cmd_ready),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    initial hwclk = 1'b0;
    always #5 hwclk = ~hwclk;

    typedef struct {
        bit         rst;
        bit         held;
        logic [4:0] code;
        bit         ready;
        bit         ev;
        logic [4:0] ec;
        int         en;
        bit         eo;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit h, input logic [4:0] c, input bit rd,
                       input bit ev, input logic [4:0] ec, input int en, input bit eo);
        vec_t v;
        v.rst = r; v.held = h; v.code = c; v.ready = rd;
        v.ev = ev; v.ec = ec; v.en = en; v.eo = eo;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, let the edge happen, sample just after it.
    task automatic step(input bit r, input bit h, input logic [4:0] c, input bit rd);
        reset = r; key_held = h; key_code = c; cmd_ready = rd;
        @(posedge hwclk);
        #1;
    endtask

    initial begin
        reset = 1'b1; key_held = 1'b0; key_code = 5'h00; cmd_ready = 1'b0;

        //   rst held code  rdy  ev ec     n  ovf
        add(1, 0, 5'h00, 0,   0, 5'h00, 0, 0);   // reset state
        add(0, 1, 5'h0A, 1,   1, 5'h0A, 1, 0);   // tap
        add(0, 1, 5'h0A, 1,   0, 5'h00, 0, 0);
        add(0, 0, 5'h00, 1,   0, 5'h00, 0, 0);
        add(0, 0, 5'h00, 1,   0, 5'h00, 0, 0);
        add(0, 1, 5'h01, 0,   1, 5'h01, 1, 0);   // overflow: five distinct codes
        add(0, 1, 5'h02, 0,   1, 5'h01, 2, 0);
        add(0, 1, 5'h03, 0,   1, 5'h01, 3, 0);
        add(0, 1, 5'h04, 0,   1, 5'h01, 4, 0);
        add(0, 1, 5'h05, 0,   1, 5'h01, 4, 1);
        add(0, 0, 5'h00, 0,   1, 5'h01, 4, 1);
        add(0, 0, 5'h00, 1,   1, 5'h02, 3, 1);
        add(0, 0, 5'h00, 1,   1, 5'h03, 2, 1);
        add(0, 0, 5'h00, 1,   1, 5'h04, 1, 1);
        add(0, 0, 5'h00, 1,   0, 5'h00, 0, 1);   // overflow is sticky
        add(1, 0, 5'h00, 0,   0, 5'h00, 0, 0);
        add(0, 1, 5'h01, 0,   1, 5'h01, 1, 0);   // full with push+pop
        add(0, 1, 5'h02, 0,   1, 5'h01, 2, 0);
        add(0, 1, 5'h03, 0,   1, 5'h01, 3, 0);
        add(0, 1, 5'h04, 0,   1, 5'h01, 4, 0);
        add(0, 1, 5'h1F, 1,   1, 5'h02, 4, 0);
        add(0, 0, 5'h00, 1,   1, 5'h03, 3, 0);
        add(0, 0, 5'h00, 1,   1, 5'h04, 2, 0);
        add(0, 0, 5'h00, 1,   1, 5'h1F, 1, 0);
        add(0, 0, 5'h00, 1,   0, 5'h00, 0, 0);
        add(0, 1, 5'h09, 1,   1, 5'h09, 1, 0);   // push+pop at count 1
        add(0, 1, 5'h0B, 1,   1, 5'h0B, 1, 0);
        add(0, 0, 5'h00, 1,   0, 5'h00, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].held, tbl[i].code, tbl[i].ready);
            chk($sformatf("vec%0d.valid", i), int'(cmd_valid),  int'(tbl[i].ev));
            chk($sformatf("vec%0d.code", i),  int'(cmd_code),   int'(tbl[i].ec));
            chk($sformatf("vec%0d.count", i), int'(fifo_count), tbl[i].en);
            chk($sformatf("vec%0d.ovf", i),   int'(overflow),   int'(tbl[i].eo));
        end

        // Long hold: pushes at 0, 8, 11, 14, 17
        step(1, 0, 5'h00, 1);
        for (int i = 0; i < 23; i++) begin
            bit exp_push;
            exp_push = (i < 20) && ((i == 0) || (i >= 8 && (i - 8) % 3 == 0));
            step(0, i < 20, 5'h03, 1);
            chk($sformatf("hold%0d.valid", i), int'(cmd_valid), int'(exp_push));
            if (exp_push) chk($sformatf("hold%0d.code", i), int'(cmd_code), 5'h03);
        end

        // Code change mid-hold: 0x02 at 0, 8; 0x07 at 10, 18
        step(1, 0, 5'h00, 1);
        for (int i = 0; i < 20; i++) begin
            bit exp_push;
            exp_push = (i == 0) || (i == 8) || (i == 10) || (i == 18);
            step(0, 1, (i < 10) ? 5'h02 : 5'h07, 1);
            chk($sformatf("chg%0d.valid", i), int'(cmd_valid), int'(exp_push));
            if (exp_push) chk($sformatf("chg%0d.code", i), int'(cmd_code),
                              (i < 10) ? 5'h02 : 5'h07);
        end

        // Reset mid-repeat with two entries queued
        step(1, 0, 5'h00, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 5'h0C, 0);
        chk("rep.count_before", int'(fifo_count), 2);
        step(1, 1, 5'h0C, 0);
        chk("rst.valid", int'(cmd_valid),  0);
        chk("rst.code",  int'(cmd_code),   0);
        chk("rst.count", int'(fifo_count), 0);
        chk("rst.ovf",   int'(overflow),   0);
        step(0, 1, 5'h0C, 0);
        chk("repress.valid", int'(cmd_valid),  1);
        chk("repress.code",  int'(cmd_code),   5'h0C);
        chk("repress.count", int'(fifo_count), 1);
        step(0, 1, 5'h0C, 0);
        chk("repress.nopush", int'(fifo_count), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_repeat_ctrl.md
KEY_REPEAT_CTRL -- requirements
Module: key_repeat_ctrl

Interface
REQ-001 Parameter: HOLD_TICKS, 24'd5_000_000, cycles from first press to first auto-repeat (500 ms at 10 MHz).
REQ-002 Parameter: REPEAT_TICKS, 24'd1_000_000, cycles between successive auto-repeats.
REQ-003 Parameter: DEPTH, 4, command FIFO entries (power of two, 2..16).
REQ-004 Port: hwclk  input  1  sole clock, all state updates on rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: key_code  input  5  binary keycode from the keypad encoder, valid only while key_held=1.
REQ-007 Port: key_held  input  1  level, high while any key is pressed (already synchronised and debounced).
REQ-008 Port: cmd_ready  input  1  consumer accepts head entry this cycle.
REQ-009 Port: cmd_valid  output  1  FIFO non-empty.
REQ-010 Port: cmd_code  output  5  head FIFO entry, meaningful only when cmd_valid=1.
REQ-011 Port: fifo_count  output  $clog2(DEPTH)+1  current occupancy.
REQ-012 Port: overflow  output  1  sticky flag, a push was dropped.

Function
REQ-013 FSM states IDLE, PRESSED, REPEAT; a 24-bit tick counter and a 5-bit last_code register.
REQ-014 IDLE with key_held=1: push key_code, latch last_code, clear counter, go PRESSED.
REQ-015 PRESSED: counter increments each cycle; when counter = HOLD_TICKS-1, push last_code, clear counter, go REPEAT.
REQ-016 REPEAT: counter increments each cycle; when counter = REPEAT_TICKS-1, push last_code, clear counter, stay REPEAT.
REQ-017 PRESSED or REPEAT with key_held=0: go IDLE, clear counter, no push; release has priority over a same-cycle counter expiry.
REQ-018 PRESSED or REPEAT with key_held=1 and key_code != last_code: treat as new press, push key_code, latch it, clear counter, go PRESSED; this has priority over counter expiry.
REQ-019 Net timing: press first sampled in cycle N -> pushes in N, N+HOLD_TICKS, N+HOLD_TICKS+k*REPEAT_TICKS (k>=1).
REQ-020 Push-to-output latency 1 cycle: entry pushed into an empty FIFO in cycle N gives cmd_valid=1, cmd_code=entry in N+1.
REQ-021 Pop occurs when cmd_valid=1 and cmd_ready=1; cmd_ready while cmd_valid=0 is ignored.
REQ-022 FIFO order strictly first-in first-out; pointers wrap modulo DEPTH.
REQ-023 Push while full with no pop in same cycle: entry dropped, contents unchanged, overflow set to 1.
REQ-024 Push and pop in same cycle when full: both take effect, count stays DEPTH, no overflow.
REQ-025 Push and pop in same cycle when count=1: both take effect, cmd_valid stays 1, new entry at head next cycle.
REQ-026 overflow clears only on reset.

Reset
REQ-027 reset=1 at a rising edge: state IDLE, counter 0, last_code 0, FIFO emptied, cmd_valid 0, cmd_code 0, fifo_count 0, overflow 0.
REQ-028 Reset mid-hold: after reset deasserts with key_held still 1, the next cycle is an IDLE press and pushes key_code (a new press).
REQ-029 All outputs are registered; no combinational input-to-output path.

Structure
REQ-030 Package key_ctrl_pkg holds CODE_W=5, the state enum type, and the default tick constants.
REQ-031 FIFO implemented as sub-module cmd_fifo (parameters DEPTH, CODE_W; push/pop/full/empty/count); FSM and counter live in key_repeat_ctrl.

Verification (HOLD_TICKS=8, REPEAT_TICKS=3, DEPTH=4)
REQ-032 Tap: key_held=1, key_code=5'h0A for 2 cycles, cmd_ready=1 -> exactly one cmd_code=0x0A, cmd_valid high 1 cycle, overflow 0.
REQ-033 Hold: key_code=5'h03 held 20 cycles from N, cmd_ready=1 -> pushes at N, N+8, N+11, N+14, N+17, each output one cycle later.
REQ-034 Overflow: cmd_ready=0, five distinct presses (0x01..0x05) -> fifo_count=4, overflow=1, then draining outputs 0x01,0x02,0x03,0x04.
REQ-035 Full with simultaneous push and pop: FIFO full, cmd_ready=1 in the same cycle as a new press 0x1F -> count stays 4, overflow 0, 0x1F emerges last.
REQ-036 Code change mid-hold: 0x02 held 10 cycles, then 0x07 without release -> push 0x07 immediately, next repeat of 0x07 8 cycles later, no further 0x02.
REQ-037 Reset mid-repeat: reset pulse while in REPEAT with 2 entries queued -> all outputs 0 next cycle, then one new push of the held code.
